gba_vga_scaler: RTL and testbench

GBA_VGA_SCALER -- requirements
Module: gba_vga_scaler

---
 rtl/gba_vga_scaler.sv | 211 +++++++++++++++++++++
 tb/tb_gba_vga_scaler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gba_vga_scaler.sv
// Upscales a BGR555 framebuffer by integer pixel replication into 640x480 VGA timing.
// Latency: 3 clk from the counter position to the R/G/B, HS, VS and vga_black_n registers.
// Backpressure: none; free-running raster, and the framebuffer must answer one clk after addr.
module gba_vga_scaler #(
    parameter int          SRC_W  = 240,
    parameter int          SRC_H  = 160,
    parameter int          SCALE  = 2,
    parameter int          H_VIS  = 640,
    parameter int          H_FP   = 16,
    parameter int          H_SYNC = 96,
    parameter int          H_BP   = 48,
    parameter int          V_VIS  = 480,
    parameter int          V_FP   = 10,
    parameter int          V_SYNC = 2,
    parameter int          V_BP   = 33,
    parameter logic [14:0] BORDER = 15'h5EF7,
    parameter int          ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              HS,
    output logic              VS,
    output logic              vga_black_n,
    output logic              vga_clk,
    output logic              vga_sync_n,
    output logic              vblank,
    output logic [7:0]        frame_cnt
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int IMG_W = SRC_W * SCALE;
    localparam int IMG_H = SRC_H * SCALE;
    localparam int X_OFF = (H_VIS - IMG_W) / 2;
    localparam int Y_OFF = (V_VIS - IMG_H) / 2;
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0] HC_XS   = HC_W'(X_OFF);
    localparam logic [HC_W-1:0] HC_XE   = HC_W'(X_OFF + IMG_W);
    localparam logic [HC_W-1:0] HC_VIS  = HC_W'(H_VIS);
    localparam logic [HC_W-1:0] HC_HS0  = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0] HC_HS1  = HC_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0] VC_YS   = VC_W'(Y_OFF);
    localparam logic [VC_W-1:0] VC_YE   = VC_W'(Y_OFF + IMG_H);
    localparam logic [VC_W-1:0] VC_VIS  = VC_W'(V_VIS);
    localparam logic [VC_W-1:0] VC_VS0  = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0] VC_VS1  = VC_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [1:0]      SUB_LAST = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    // An image that does not fit the visible area cannot be centred.
    if (X_OFF < 0 || Y_OFF < 0) begin : g_bad_offset
        $error("gba_vga_scaler: scaled image larger than the visible area");
    end
    if (SCALE < 1 || SCALE > 3) begin : g_bad_scale
        $error("gba_vga_scaler: SCALE must be 1..3");
    end

    // Per-pixel attributes carried alongside the framebuffer read.
    typedef struct packed {
        logic inimg;
        logic vis;
        logic hs_n;
        logic vs_n;
        logic vbl;
    } flags_t;

    localparam flags_t FLAGS_RST = '{inimg: 1'b0, vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, vbl: 1'b0};

    logic [HC_W-1:0]   hc_q, hc_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [1:0]        hsub_q, hsub_d, vsub_q, vsub_d;
    logic [ADDR_W-1:0] col_q, col_d, row_q, row_d, addr_q, addr_d;
    flags_t            cur, s1_q, s1_d, s2_q, s2_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d, frame_cnt_q, frame_cnt_d;
    logic              hs_q, hs_d, vs_q, vs_d, black_n_q, black_n_d, vblank_q, vblank_d;
    logic              line_end, in_h, in_v;
    logic [14:0]       colour;

    // Bit 15 of the framebuffer word carries no colour.
    logic data_unused;
    assign data_unused = data[15];

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // Raster counters, multiplier-free address walk, and the 3-stage output pipeline.
    always_comb begin
        line_end = (hc_q == HC_LAST);
        hc_d     = line_end ? '0 : hc_q + 1'b1;
        vc_d     = vc_q;
        if (line_end) begin
            vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
        end

        in_h      = (hc_q >= HC_XS) && (hc_q < HC_XE);
        in_v      = (vc_q >= VC_YS) && (vc_q < VC_YE);
        cur.inimg = in_h && in_v;
        cur.vis   = (hc_q < HC_VIS) && (vc_q < VC_VIS);
        cur.hs_n  = !((hc_q >= HC_HS0) && (hc_q < HC_HS1));
        cur.vs_n  = !((vc_q >= VC_VS0) && (vc_q < VC_VS1));
        cur.vbl   = (hc_q == '0) && (vc_q == VC_VIS);

        // Column restarts on the clock before the image's first column.
        col_d  = col_q;
        hsub_d = hsub_q;
        if (hc_d == HC_XS) begin
            col_d  = '0;
            hsub_d = '0;
        end else if (cur.inimg) begin
            if (hsub_q == SUB_LAST) begin
                hsub_d = '0;
                col_d  = col_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 1'b1;
            end
        end

        // Row base restarts at the end of the line before the image's first line.
        row_d  = row_q;
        vsub_d = vsub_q;
        if (line_end) begin
            if (vc_d == VC_YS) begin
                row_d  = '0;
                vsub_d = '0;
            end else if (in_v) begin
                if (vsub_q == SUB_LAST) begin
                    vsub_d = '0;
                    row_d  = row_q + ROW_STEP;
                end else begin
                    vsub_d = vsub_q + 1'b1;
                end
            end
        end

        addr_d = cur.inimg ? (row_q + col_q) : '0;
        s1_d   = cur;
        s2_d   = s1_q;

        colour      = s2_q.inimg ? data[14:0] : BORDER;
        r_d         = s2_q.vis ? expand5(colour[4:0])   : 8'h00;
        g_d         = s2_q.vis ? expand5(colour[9:5])   : 8'h00;
        b_d         = s2_q.vis ? expand5(colour[14:10]) : 8'h00;
        hs_d        = s2_q.hs_n;
        vs_d        = s2_q.vs_n;
        black_n_d   = s2_q.vis;
        vblank_d    = s2_q.vbl;
        frame_cnt_d = frame_cnt_q + {7'd0, s2_q.vbl};
    end

    // State registers; reset drops every in-flight pixel and parks syncs inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q        <= '0;
            vc_q        <= '0;
            hsub_q      <= '0;
            vsub_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            s1_q        <= FLAGS_RST;
            s2_q        <= FLAGS_RST;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            black_n_q   <= 1'b0;
            vblank_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            hsub_q      <= hsub_d;
            vsub_q      <= vsub_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            black_n_q   <= black_n_d;
            vblank_q    <= vblank_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign addr        = addr_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign vga_black_n = black_n_q;
    assign vblank      = vblank_q;
    assign frame_cnt   = frame_cnt_q;
    assign vga_clk     = ~clk;
    assign vga_sync_n  = 1'b1;
endmodule

// File: tb/tb_gba_vga_scaler.sv
// Directed bench: default-size scaler for mapping/colour/HS, shrunken rasters for frame-level behaviour.
// Latency: expectations index pixel (x,y) at clk y*H_TOT+x+1 for addr and +3 for outputs.
// Backpressure: none; framebuffer model answers one clk after addr.
module tb_gba_vga_scaler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def = 1'b1;
    logic rst_sml = 1'b1;

    logic [15:0] addr_def, addr_sml, addr_one;
    logic [15:0] data_def, data_sml, data_one;
    logic [7:0]  r_def, g_def, b_def, fc_def, r_sml, g_sml, b_sml, fc_sml, r_one, g_one, b_one, fc_one;
    logic        hs_def, vs_def, bn_def, vc_def, sn_def, vb_def;
    logic        hs_sml, vs_sml, bn_sml, vc_sml, sn_sml, vb_sml;
    logic        hs_one, vs_one, bn_one, vc_one, sn_one, vb_one;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc_def, cyc_sml;

    gba_vga_scaler u_def (
        .clk(clk), .rst(rst_def), .addr(addr_def), .data(data_def),
        .R(r_def), .G(g_def), .B(b_def), .HS(hs_def), .VS(vs_def),
        .vga_black_n(bn_def), .vga_clk(vc_def), .vga_sync_n(sn_def),
        .vblank(vb_def), .frame_cnt(fc_def)
    );

    // 4x2 source doubled into a 14x9 raster: X_OFF = 1, Y_OFF = 1, 126 clks per frame.
    gba_vga_scaler #(
        .SRC_W(4), .SRC_H(2), .SCALE(2), .H_VIS(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(6), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .clk(clk), .rst(rst_sml), .addr(addr_sml), .data(data_sml),
        .R(r_sml), .G(g_sml), .B(b_sml), .HS(hs_sml), .VS(vs_sml),
        .vga_black_n(bn_sml), .vga_clk(vc_sml), .vga_sync_n(sn_sml),
        .vblank(vb_sml), .frame_cnt(fc_sml)
    );

    // Same raster at SCALE = 1: X_OFF = 3, Y_OFF = 2.
    gba_vga_scaler #(
        .SRC_W(4), .SRC_H(2), .SCALE(1), .H_VIS(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(6), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_one (
        .clk(clk), .rst(rst_sml), .addr(addr_one), .data(data_one),
        .R(r_one), .G(g_one), .B(b_one), .HS(hs_one), .VS(vs_one),
        .vga_black_n(bn_one), .vga_clk(vc_one), .vga_sync_n(sn_one),
        .vblank(vb_one), .frame_cnt(fc_one)
    );

    assign data_one = 16'h0000;

    // Framebuffer contents: word 0 is pure red with the ignored bit 15 set, others hold their address.
    function automatic logic [15:0] fb(input logic [15:0] a);
        return (a == 16'd0) ? 16'h801F : a;
    endfunction

    always @(posedge clk) begin
        data_def <= fb(addr_def);
        data_sml <= fb(addr_sml);
    end

    always @(posedge clk or posedge rst_def)
        if (rst_def) cyc_def <= 0; else cyc_def <= cyc_def + 1;
    always @(posedge clk or posedge rst_sml)
        if (rst_sml) cyc_sml <= 0; else cyc_sml <= cyc_sml + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the negedge following clk edge 'target' of the selected counter.
    task automatic wait_to(input bit sml, input int target);
        int g;
        g = 0;
        while (((sml ? cyc_sml : cyc_def) < target) && g < 100000) begin
            @(negedge clk);
            g++;
        end
        if ((sml ? cyc_sml : cyc_def) != target)
            chk(sml ? "wait_sml" : "wait_def", sml ? cyc_sml : cyc_def, target);
    endtask

    int hs_low_def;
    int hist[8];
    int bad, vs_low, hs_low, vbl_cnt, hs_low2, pos, hcp, vcp;
    bit inimg;

    initial begin
        fork
            begin : default_branch
                repeat (3) @(negedge clk);
                chk("def_rst_addr", addr_def, 0);
                chk("def_rst_rgb", {r_def, g_def, b_def}, 0);
                chk("def_rst_hsvs", {hs_def, vs_def}, 2'b11);
                chk("def_rst_black_n", bn_def, 0);
                chk("def_rst_vblank", vb_def, 0);
                chk("def_rst_frame_cnt", fc_def, 0);
                rst_def = 1'b0;
                hs_low_def = 0;
                for (int i = 1; i <= 800; i++) begin
                    wait_to(0, i);
                    if (!hs_def) hs_low_def++;
                    if (i == 3) begin
                        chk("def_first_pixel_black_n", bn_def, 1);
                        chk("def_vga_clk", vc_def, 1);
                        chk("def_vga_sync_n", sn_def, 1);
                    end
                    if (i == 658) chk("def_hs_658", hs_def, 1);
                    if (i == 659) chk("def_hs_659", hs_def, 0);
                    if (i == 754) chk("def_hs_754", hs_def, 0);
                    if (i == 755) chk("def_hs_755", hs_def, 1);
                    if (i == 703) begin
                        chk("def_offvis_rgb", {r_def, g_def, b_def}, 0);
                        chk("def_offvis_black_n", bn_def, 0);
                    end
                end
                chk("def_hs_low_line", hs_low_def, 96);
                wait_to(0, 64081); chk("def_addr_80_80", addr_def, 0);
                wait_to(0, 64082); chk("def_addr_81_80", addr_def, 0);
                chk("def_border_rgb", {r_def, g_def, b_def}, 24'hBDBDBD);
                chk("def_border_black_n", bn_def, 1);
                wait_to(0, 64083); chk("def_addr_82_80", addr_def, 1);
                chk("def_red_rgb", {r_def, g_def, b_def}, 24'hFF0000);
                wait_to(0, 64085); chk("def_pix_82_80_rgb", {r_def, g_def, b_def}, 24'h080000);
                wait_to(0, 64881); chk("def_addr_80_81", addr_def, 0);
                wait_to(0, 64883); chk("def_addr_82_81", addr_def, 1);
                wait_to(0, 65681); chk("def_addr_80_82", addr_def, 240);
                wait_to(0, 65683); chk("def_pix_80_82_rgb", {r_def, g_def, b_def}, 24'h843900);
                wait_to(0, 65684); chk("def_addr_83_82", addr_def, 241);
            end
            begin : small_branch
                repeat (3) @(negedge clk);
                rst_sml = 1'b0;
                for (int k = 0; k < 8; k++) hist[k] = 0;
                bad = 0; vs_low = 0; hs_low = 0; vbl_cnt = 0;
                for (int i = 1; i <= 126; i++) begin
                    wait_to(1, i);
                    pos = i - 1;
                    hcp = pos % 14;
                    vcp = pos / 14;
                    inimg = (hcp >= 1) && (hcp < 9) && (vcp >= 1) && (vcp < 5);
                    if (inimg) begin
                        if (addr_sml < 16'd8) hist[addr_sml[2:0]]++; else bad++;
                    end else if (addr_sml != 16'd0) begin
                        bad++;
                    end
                    if (!vs_sml) vs_low++;
                    if (i >= 3 && i <= 16 && !hs_sml) hs_low++;
                    if (vb_sml) vbl_cnt++;
                    case (i)
                        2:  chk("sml_black_n_2", bn_sml, 0);
                        3:  chk("sml_black_n_3", bn_sml, 1);
                        13: chk("sml_offvis", {bn_sml, r_sml, g_sml, b_sml}, 0);
                        17: chk("sml_border", {r_sml, g_sml, b_sml}, 24'hBDBDBD);
                        18: chk("sml_red", {r_sml, g_sml, b_sml}, 24'hFF0000);
                        33: chk("one_addr_4_2", addr_one, 1);
                        34: chk("one_addr_5_2", addr_one, 2);
                        46: chk("one_addr_3_3", addr_one, 4);
                        49: chk("one_addr_6_3", addr_one, 7);
                        50: chk("one_addr_7_3", addr_one, 0);
                        65: chk("sml_addr_last", addr_sml, 7);
                        86: chk("sml_vbl_86", {vb_sml, fc_sml}, 9'h000);
                        87: chk("sml_vbl_87", {vb_sml, fc_sml}, 9'h101);
                        default: ;
                    endcase
                end
                for (int k = 0; k < 8; k++) chk($sformatf("sml_hist_%0d", k), hist[k], 4);
                chk("sml_addr_stray", bad, 0);
                chk("sml_vs_low", vs_low, 14);
                chk("sml_hs_low", hs_low, 2);
                chk("sml_vblank_count", vbl_cnt, 1);
                wait_to(1, 213);   chk("sml_vbl_213", {vb_sml, fc_sml}, 9'h102);
                wait_to(1, 32216); chk("sml_fc_255", {vb_sml, fc_sml}, 9'h0FF);
                wait_to(1, 32217); chk("sml_fc_wrap", {vb_sml, fc_sml}, 9'h100);
                wait_to(1, 32418);
                chk("sml_pre_rst", {bn_sml, fc_sml, addr_sml}, {1'b1, 8'd1, 16'd3});
                #2 rst_sml = 1'b1;
                #1;
                chk("sml_async_addr", addr_sml, 0);
                chk("sml_async_rgb", {r_sml, g_sml, b_sml}, 0);
                chk("sml_async_sync", {hs_sml, vs_sml, bn_sml, vb_sml}, 4'b1100);
                chk("sml_async_fc", fc_sml, 0);
                repeat (2) @(negedge clk);
                rst_sml = 1'b0;
                hs_low2 = 0;
                for (int i = 1; i <= 16; i++) begin
                    wait_to(1, i);
                    if (!hs_sml) hs_low2++;
                    if (i == 2)  chk("rel_black_n_2", bn_sml, 0);
                    if (i == 3)  chk("rel_black_n_3", bn_sml, 1);
                    if (i == 13) chk("rel_hs_13", hs_sml, 1);
                    if (i == 14) chk("rel_hs_14", hs_sml, 0);
                end
                chk("rel_hs_low", hs_low2, 2);
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
